// File: rtl/pc_fetch_seq_if.sv
// Fetch-sequencer bus: instruction-memory handshake, decode-side outputs and branch feedback.
// The master side is the fetch sequencer; the slave side is memory, decode and the branch unit.
interface pc_fetch_seq_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
);
  logic               stall;
  logic               brnch_take;
  logic               brnch_rel;
  logic [ADDR_W-1:0]  brnch_tgt;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rdy;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_vld;
  logic [ADDR_W-1:0]  pc_out;
  logic               flush;

  modport master (
    input  stall, brnch_take, brnch_rel, brnch_tgt, imem_rdy, imem_data,
    output imem_req, imem_addr, instr_out, instr_vld, pc_out, flush
  );

  modport slave (
    output stall, brnch_take, brnch_rel, brnch_tgt, imem_rdy, imem_data,
    input  imem_req, imem_addr, instr_out, instr_vld, pc_out, flush
  );
endinterface

// File: rtl/pc_fetch_seq.sv
// Program counter and instruction-fetch sequencer: requests instructions from ROM, presents
// them to decode with their address, and redirects the PC on taken branches.
module pc_fetch_seq #(
  parameter int unsigned      ADDR_W   = 8,
  parameter int unsigned      INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic            clk,
  input logic            rst_n,
  pc_fetch_seq_if.master bus
);

  typedef enum logic [1:0] {StIdle, StReq, StValid} state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               req_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [INSTR_W-1:0] instr_q;
  logic               vld_q;
  logic [ADDR_W-1:0]  pc_out_q;
  logic               flush_q;

  logic [ADDR_W-1:0]  seq_pc;
  logic [ADDR_W-1:0]  br_pc;
  logic [ADDR_W-1:0]  next_pc;

  // Modulo-2^ADDR_W adds; a relative offset of all-ones-ish values wraps as a negative step.
  always_comb begin
    seq_pc  = pc_out_q + ADDR_W'(1);
    br_pc   = bus.brnch_rel ? (pc_out_q + bus.brnch_tgt) : bus.brnch_tgt;
    next_pc = bus.brnch_take ? br_pc : seq_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= '0;
      instr_q  <= '0;
      vld_q    <= 1'b0;
      pc_out_q <= '0;
      flush_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          req_q   <= 1'b1;
          addr_q  <= pc_q;
          state_q <= StReq;
        end
        StReq: begin
          flush_q <= 1'b0;
          if (bus.imem_rdy) begin
            instr_q  <= bus.imem_data;
            pc_out_q <= pc_q;
            vld_q    <= 1'b1;
            req_q    <= 1'b0;
            state_q  <= StValid;
          end
        end
        StValid: begin
          // Stall beats a taken branch; the branch unit holds take until stall drops.
          if (!bus.stall) begin
            pc_q    <= next_pc;
            addr_q  <= next_pc;
            req_q   <= 1'b1;
            vld_q   <= 1'b0;
            flush_q <= bus.brnch_take;
            state_q <= StReq;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.instr_out = instr_q;
  assign bus.instr_vld = vld_q;
  assign bus.pc_out    = pc_out_q;
  assign bus.flush     = flush_q;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq: sequential fetch, absolute/relative branches, stall,
// memory wait states and asynchronous reset in the middle of a request.
module tb_pc_fetch_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pc_fetch_seq_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

  pc_fetch_seq #(
    .ADDR_W  (8),
    .INSTR_W (16),
    .RESET_PC(8'h00)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ROM model: word is tagged with its address; garbage while not ready.
  assign bus.imem_data = bus.imem_rdy ? {8'hC0, bus.imem_addr} : 16'hDEAD;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_req(input logic [7:0] a, input logic fl);
    check_eq("req", 32'(bus.imem_req), 32'd1);
    check_eq("req_addr", 32'(bus.imem_addr), 32'(a));
    check_eq("req_vld", 32'(bus.instr_vld), 32'd0);
    check_eq("req_flush", 32'(bus.flush), 32'(fl));
  endtask

  task automatic exp_vld(input logic [7:0] a);
    check_eq("vld", 32'(bus.instr_vld), 32'd1);
    check_eq("vld_req", 32'(bus.imem_req), 32'd0);
    check_eq("vld_pc", 32'(bus.pc_out), 32'(a));
    check_eq("vld_instr", 32'(bus.instr_out), 32'({8'hC0, a}));
    check_eq("vld_flush", 32'(bus.flush), 32'd0);
  endtask

  task automatic exp_zero();
    check_eq("rst_req", 32'(bus.imem_req), 32'd0);
    check_eq("rst_addr", 32'(bus.imem_addr), 32'd0);
    check_eq("rst_instr", 32'(bus.instr_out), 32'd0);
    check_eq("rst_vld", 32'(bus.instr_vld), 32'd0);
    check_eq("rst_pc", 32'(bus.pc_out), 32'd0);
    check_eq("rst_flush", 32'(bus.flush), 32'd0);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.stall      = 1'b0;
    bus.brnch_take = 1'b0;
    bus.brnch_rel  = 1'b0;
    bus.brnch_tgt  = 8'h00;
    bus.imem_rdy   = 1'b1;

    repeat (2) @(negedge clk);
    exp_zero();
    rst_n = 1'b1;

    // Sequential fetch 0..5, one instruction every two cycles
    for (int a = 0; a < 6; a++) begin
      @(negedge clk); exp_req(8'(a), 1'b0);
      @(negedge clk); exp_vld(8'(a));
    end

    // Absolute branch from 0x05 to 0x40
    bus.brnch_take = 1'b1; bus.brnch_rel = 1'b0; bus.brnch_tgt = 8'h40;
    @(negedge clk); exp_req(8'h40, 1'b1);
    bus.brnch_take = 1'b0;
    @(negedge clk); exp_vld(8'h40);
    @(negedge clk); exp_req(8'h41, 1'b0);
    @(negedge clk); exp_vld(8'h41);

    // Jump to 0x01, then relative -2 wraps to 0xFF, then sequential wraps to 0x00
    bus.brnch_take = 1'b1; bus.brnch_tgt = 8'h01;
    @(negedge clk); exp_req(8'h01, 1'b1);
    bus.brnch_take = 1'b0;
    @(negedge clk); exp_vld(8'h01);
    bus.brnch_take = 1'b1; bus.brnch_rel = 1'b1; bus.brnch_tgt = 8'hFE;
    @(negedge clk); exp_req(8'hFF, 1'b1);
    bus.brnch_take = 1'b0; bus.brnch_rel = 1'b0;
    @(negedge clk); exp_vld(8'hFF);
    @(negedge clk); exp_req(8'h00, 1'b0);
    @(negedge clk); exp_vld(8'h00);

    // Stall with a pending taken branch: everything holds, branch ignored
    bus.stall = 1'b1; bus.brnch_take = 1'b1; bus.brnch_tgt = 8'h77;
    repeat (4) begin
      @(negedge clk); exp_vld(8'h00);
    end
    bus.stall = 1'b0; bus.brnch_take = 1'b0;
    @(negedge clk); exp_req(8'h01, 1'b0);
    @(negedge clk); exp_vld(8'h01);

    // Branch to 0x10 with memory not ready for three edges
    bus.brnch_take = 1'b1; bus.brnch_tgt = 8'h10; bus.imem_rdy = 1'b0;
    @(negedge clk); exp_req(8'h10, 1'b1);
    check_eq("wait_instr", 32'(bus.instr_out), 32'hC001);
    bus.brnch_take = 1'b0;
    repeat (3) begin
      @(negedge clk); exp_req(8'h10, 1'b0);
      check_eq("wait_instr", 32'(bus.instr_out), 32'hC001);
    end
    bus.imem_rdy = 1'b1;
    @(negedge clk); exp_vld(8'h10);

    // Async reset between edges while a request is outstanding
    bus.imem_rdy = 1'b0;
    @(negedge clk); exp_req(8'h11, 1'b0);
    #2 rst_n = 1'b0;
    #1 exp_zero();
    bus.imem_rdy = 1'b1;
    @(negedge clk); exp_zero();
    rst_n = 1'b1;
    @(negedge clk); exp_req(8'h00, 1'b0);
    @(negedge clk); exp_vld(8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_seq.md
Name: pc_fetch_seq

Overview:
- Program-counter and instruction-fetch sequencer for the Harvard Architecture Processor.
- Receiving end of the compare/branch unit: it consumes the branch decision, mode and target, then redirects the PC.
- Drives the instruction-memory request handshake and presents each fetched instruction, with its address, to decode.
- Sits between instruction ROM and decode; the branch unit feeds back into it.

Parameters:
ADDR_W, 8, PC / instruction-memory address width
INSTR_W, 16, instruction word width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
stall  in  1  decode cannot accept; hold current instruction
brnch_take  in  1  branch unit: taken decision for the presented instruction
brnch_rel  in  1  1 = target is signed offset from instruction PC; 0 = absolute target
brnch_tgt  in  ADDR_W  absolute target or two's-complement offset
imem_req  out  1  instruction memory read request
imem_addr  out  ADDR_W  read address
imem_rdy  in  1  memory returns imem_data this cycle
imem_data  in  INSTR_W  instruction word
instr_out  out  INSTR_W  registered instruction to decode
instr_vld  out  1  instr_out/pc_out valid
pc_out  out  ADDR_W  address of instr_out
flush  out  1  one-cycle pulse: taken redirect

Behaviour:
- Single clock clk; rst_n is asynchronous, active-low. All registers update on the rising clk edge only.
- Reset (async assert, any state including mid-request):
  - state=IDLE, pc=RESET_PC.
  - imem_req=0, imem_addr=0, instr_out=0, instr_vld=0, pc_out=0, flush=0.
  - A pending memory request is abandoned. A late imem_rdy after reset is ignored unless the FSM is in REQ.
- FSM states: IDLE, REQ, VALID.
  - IDLE: outputs idle; next cycle -> REQ. The first request is issued exactly 1 cycle after rst_n deasserts.
  - REQ:
    - imem_req=1 and imem_addr=pc, held stable until imem_rdy.
    - On imem_rdy: instr_out<=imem_data, pc_out<=pc, instr_vld<=1, -> VALID.
    - imem_rdy=0: stay; address must not change.
  - VALID:
    - instr_vld=1, imem_req=0.
    - stall=1: hold instr_out/pc_out/instr_vld; brnch_take ignored.
    - stall=0, brnch_take=0: pc<=pc_out+1, instr_vld<=0, -> REQ.
    - stall=0, brnch_take=1:
      - pc<=(brnch_rel ? pc_out+brnch_tgt : brnch_tgt).
      - flush<=1 for exactly one cycle; instr_vld<=0; -> REQ.
- brnch_take/brnch_rel/brnch_tgt are sampled only in VALID with stall=0; ignored in IDLE/REQ.
- Arithmetic:
  - All PC math is modulo 2^ADDR_W. pc 0xFF+1 -> 0x00.
  - Relative offset is sign-interpreted at ADDR_W width, so 0xFE means -2.
  - Offset 0 gives a self-loop (refetch same address).
- Throughput: 2 cycles/instruction minimum (REQ with immediate rdy, then VALID); +1 cycle per imem_rdy wait cycle.
- flush is asserted in the first REQ cycle following the taken branch, never otherwise.
- Stall and take in the same cycle: stall wins. The branch unit must hold take until stall drops.

Test Plan:
- Reset release, imem_rdy tied 1, data=addr pattern -> imem_addr sequence 0x00,0x01,0x02 on REQ cycles; pc_out matches; instr_vld every other cycle.
- Absolute branch: at pc_out=0x05 assert brnch_take=1, rel=0, tgt=0x40 -> flush pulses 1 cycle, next imem_addr=0x40, then 0x41.
- Relative wrap: at pc_out=0x01, rel=1, tgt=0xFE -> next imem_addr=0xFF; following sequential fetch -> 0x00.
- Stall: hold stall=1 for 4 cycles in VALID with brnch_take=1 -> instr_out/pc_out stable, no imem_req, no flush; drop stall with take=0 -> fetch pc_out+1.
- Memory wait: imem_rdy low 3 cycles at addr 0x10 -> imem_req and imem_addr=0x10 stable for all 4 cycles; instruction captured only on the rdy cycle.
- Async reset mid-REQ (rst_n low between edges) -> outputs zero immediately; after release, the first request is to RESET_PC.
